// File: rtl/wptr_full_gen_if.sv
// Write-side FIFO bus between the producer/synchronizer side and wptr_full_gen.
//   wr_en          : write request from the producer
//   rd_ptr_sync    : Gray read pointer, already in the write clock domain
//   wr_addr        : binary memory write address
//   wr_ptr         : registered Gray write pointer toward the read domain
//   wr_mem_en      : combinational memory write strobe
//   wr_full        : registered full flag
//   wr_level       : registered fill level, 0 .. 2^add_size
//   wr_ovf         : sticky overflow error
//   wr_almost_full : registered almost-full flag (WPTR_ALMOST_FULL_EN only)
// Optional feature macro: WPTR_ALMOST_FULL_EN
interface wptr_full_gen_if #(
  parameter int unsigned add_size = 8
);
  logic                wr_en;
  logic [add_size:0]   rd_ptr_sync;
  logic [add_size-1:0] wr_addr;
  logic [add_size:0]   wr_ptr;
  logic                wr_mem_en;
  logic                wr_full;
  logic [add_size:0]   wr_level;
  logic                wr_ovf;
`ifdef WPTR_ALMOST_FULL_EN
  logic                wr_almost_full;
`endif

  // Producer / synchronizer side
  modport master (
    output wr_en, rd_ptr_sync,
    input  wr_addr, wr_ptr, wr_mem_en, wr_full, wr_level, wr_ovf
`ifdef WPTR_ALMOST_FULL_EN
    , input wr_almost_full
`endif
  );

  // Pointer/flag generator side
  modport slave (
    input  wr_en, rd_ptr_sync,
    output wr_addr, wr_ptr, wr_mem_en, wr_full, wr_level, wr_ovf
`ifdef WPTR_ALMOST_FULL_EN
    , output wr_almost_full
`endif
  );
endinterface

// File: rtl/wptr_full_gen.sv
// Write-side pointer and full-flag generator for an asynchronous FIFO,
// running in the write clock domain. Produces the memory write address,
// the Gray write pointer for the read-domain synchronizer, a zero-lag full
// flag, a fill level and a sticky overflow error; gates every memory write.
// Ports:
//   wr_clk : write-domain clock
//   wr_rst : asynchronous active-low reset
//   bus    : wptr_full_gen_if.slave (see interface file for signal list)
// Optional feature macro: WPTR_ALMOST_FULL_EN adds wr_almost_full and the
// AF_LEVEL threshold parameter.
module wptr_full_gen #(
  parameter int unsigned add_size = 8
`ifdef WPTR_ALMOST_FULL_EN
  , parameter int unsigned AF_LEVEL = (2 ** add_size) - 4
`endif
) (
  input  logic           wr_clk,
  input  logic           wr_rst,
  wptr_full_gen_if.slave bus
);

  localparam int unsigned PW = add_size + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;

  // Write strobe: a request is accepted only while not full
  assign bus.wr_mem_en = bus.wr_en & ~bus.wr_full;

  assign bus.wr_addr = wbin[add_size-1:0];

  // Next pointer, its Gray form and the full-compare pattern (top two bits
  // of the read pointer inverted: one lap ahead, same address)
  always_comb begin
    wbin_next  = wbin + PW'(bus.wr_mem_en);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_cmp   = {~bus.rd_ptr_sync[add_size:add_size-1],
                  bus.rd_ptr_sync[add_size-2:0]};
  end

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(bus.rd_ptr_sync >> i);
    end
  end

  assign level_next = wbin_next - rbin;

  // Pointer, flag and level registers
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      wbin         <= '0;
      bus.wr_ptr   <= '0;
      bus.wr_full  <= 1'b0;
      bus.wr_level <= '0;
      bus.wr_ovf   <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      bus.wr_ptr   <= wgray_next;
      bus.wr_full  <= (wgray_next == full_cmp);
      bus.wr_level <= level_next;
      bus.wr_ovf   <= bus.wr_ovf | (bus.wr_en & bus.wr_full);
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  // Almost-full threshold on the same next-level arithmetic as wr_level
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      bus.wr_almost_full <= 1'b0;
    end else begin
      bus.wr_almost_full <= (level_next >= PW'(AF_LEVEL));
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed bench for wptr_full_gen with add_size = 8: reset, fill to full,
// overflow, drain one, simultaneous write/read, wrap with tracking reader,
// asynchronous reset mid-burst, and almost-full when WPTR_ALMOST_FULL_EN.
module tb_wptr_full_gen;

  localparam int unsigned AS = 8;

  logic wr_clk = 1'b0;
  logic wr_rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   full_seen;

  wptr_full_gen_if #(.add_size(AS)) bus ();

`ifdef WPTR_ALMOST_FULL_EN
  wptr_full_gen #(.add_size(AS), .AF_LEVEL(252)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus.slave)
  );
`else
  wptr_full_gen #(.add_size(AS)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus.slave)
  );
`endif

  always #5 wr_clk = ~wr_clk;

  function automatic logic [AS:0] gray(input int unsigned v);
    logic [AS:0] b;
    b = (AS+1)'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_addr"},  32'(bus.wr_addr),  32'h0);
    check({tag, "_ptr"},   32'(bus.wr_ptr),   32'h0);
    check({tag, "_full"},  32'(bus.wr_full),  32'h0);
    check({tag, "_level"}, 32'(bus.wr_level), 32'h0);
    check({tag, "_ovf"},   32'(bus.wr_ovf),   32'h0);
`ifdef WPTR_ALMOST_FULL_EN
    check({tag, "_af"},    32'(bus.wr_almost_full), 32'h0);
`endif
  endtask

  initial begin
    // Reset with arbitrary inputs
    wr_rst          = 1'b0;
    bus.wr_en       = 1'b1;
    bus.rd_ptr_sync = (AS+1)'($urandom);
    #3;
    check_cleared("rst0");
    repeat (2) step();
    check_cleared("rst1");
    check("rst_mem_en_req", 32'(bus.wr_mem_en), 32'h1);
    bus.wr_en = 1'b0;
    #1;
    check("rst_mem_en_idle", 32'(bus.wr_mem_en), 32'h0);

    // Fill: 256 writes with the reader parked at 0
    step();
    wr_rst          = 1'b1;
    bus.rd_ptr_sync = '0;
    bus.wr_en       = 1'b1;
    repeat (255) step();
    check("fill255_full",  32'(bus.wr_full),  32'h0);
    check("fill255_addr",  32'(bus.wr_addr),  32'hff);
    check("fill255_ptr",   32'(bus.wr_ptr),   32'h080);
    check("fill255_level", 32'(bus.wr_level), 32'd255);
    step();
    check("fill256_full",  32'(bus.wr_full),  32'h1);
    check("fill256_addr",  32'(bus.wr_addr),  32'h00);
    check("fill256_ptr",   32'(bus.wr_ptr),   32'h180);
    check("fill256_level", 32'(bus.wr_level), 32'd256);
    check("fill256_ovf",   32'(bus.wr_ovf),   32'h0);
    check("fill256_memen", 32'(bus.wr_mem_en), 32'h0);

    // Overflow: write while full is rejected and sets the sticky error
    step();
    check("ovf_addr",  32'(bus.wr_addr),  32'h00);
    check("ovf_ptr",   32'(bus.wr_ptr),   32'h180);
    check("ovf_level", 32'(bus.wr_level), 32'd256);
    check("ovf_full",  32'(bus.wr_full),  32'h1);
    check("ovf_flag",  32'(bus.wr_ovf),   32'h1);

    // Drain one: reader advances to 1, no write
    bus.wr_en       = 1'b0;
    bus.rd_ptr_sync = 9'h001;
    step();
    check("drain_full",  32'(bus.wr_full),  32'h0);
    check("drain_level", 32'(bus.wr_level), 32'd255);
    check("drain_ovf",   32'(bus.wr_ovf),   32'h1);

    // Simultaneous write and read: level holds
    bus.wr_en       = 1'b1;
    bus.rd_ptr_sync = 9'h003;
    step();
    check("wr_rd_level", 32'(bus.wr_level), 32'd255);
    check("wr_rd_addr",  32'(bus.wr_addr),  32'h01);
    check("wr_rd_ptr",   32'(bus.wr_ptr),   32'h181);
    check("wr_rd_full",  32'(bus.wr_full),  32'h0);
    check("wr_rd_ovf",   32'(bus.wr_ovf),   32'h1);

    // Asynchronous reset mid-burst clears before the next edge
    #2;
    wr_rst = 1'b0;
    #1;
    check_cleared("async_rst");
    bus.wr_en = 1'b0;
    step();
    wr_rst = 1'b1;

    // Wrap: 512 writes with the reader one entry behind
    bus.wr_en = 1'b1;
    full_seen = 0;
    for (int i = 0; i < 512; i++) begin
      bus.rd_ptr_sync = gray(i);
      step();
      if (bus.wr_full) full_seen++;
      if (i == 255) check("wrap_mid_ptr", 32'(bus.wr_ptr), 32'h180);
    end
    check("wrap_full_never", 32'(full_seen),    32'd0);
    check("wrap_ptr",        32'(bus.wr_ptr),   32'h000);
    check("wrap_addr",       32'(bus.wr_addr),  32'h00);
    check("wrap_level",      32'(bus.wr_level), 32'd1);

`ifdef WPTR_ALMOST_FULL_EN
    // Almost-full rises on the 252nd write, then reset mid-burst
    wr_rst    = 1'b0;
    bus.wr_en = 1'b0;
    step();
    wr_rst          = 1'b1;
    bus.rd_ptr_sync = '0;
    bus.wr_en       = 1'b1;
    repeat (251) step();
    check("af251",       32'(bus.wr_almost_full), 32'h0);
    check("af251_level", 32'(bus.wr_level),       32'd251);
    step();
    check("af252",       32'(bus.wr_almost_full), 32'h1);
    check("af252_level", 32'(bus.wr_level),       32'd252);
    #2;
    wr_rst = 1'b0;
    #1;
    check_cleared("af_async_rst");
    wr_rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wptr_full_gen.md
# wptr_full_gen

Write-side pointer and full-flag generator for the asynchronous FIFO, in the write clock domain. It consumes the Gray-coded read pointer produced by the read-to-write synchronizer. From it, the block derives the write address, the Gray write pointer sent to the read-domain synchronizer, the full flag, a fill level and a sticky overflow error. It gates every FIFO memory write.

## Interface
- `add_size`, default 8: address width; FIFO depth is 2^add_size; legal range ≥ 2.
- `AF_LEVEL`, default 2^add_size − 4: almost-full threshold in entries; used only with `WPTR_ALMOST_FULL_EN`.

- `wr_clk` in 1: write-domain clock; all state updates on rising edge.
- `wr_rst` in 1: asynchronous, active-low reset; assertion clears all state immediately; release is synchronous to `wr_clk` externally.
- `wr_en` in 1: write request from the producer.
- `rd_ptr_sync` in add_size+1: Gray read pointer, already synchronized to `wr_clk`.
- `wr_addr` out add_size: binary memory write address (low bits of the binary pointer).
- `wr_ptr` out add_size+1: registered Gray write pointer, sent to the write-to-read synchronizer.
- `wr_mem_en` out 1: memory write strobe = `wr_en` & ~`wr_full` (combinational).
- `wr_full` out 1: registered full flag.
- `wr_level` out add_size+1: registered entry count, 0 … 2^add_size.
- `wr_ovf` out 1: sticky overflow error.
- `wr_almost_full` out 1: registered; present only with `WPTR_ALMOST_FULL_EN`.

## Operation
- **State:** binary pointer `wbin` [add_size:0] and Gray pointer `wr_ptr`; both register the same value, with `wr_ptr` = `wbin` ^ (`wbin`>>1).
- **Accept:** a write is accepted when `wr_mem_en` = 1. Then `wbin_next` = `wbin` + 1, modulo 2^(add_size+1); otherwise `wbin_next` = `wbin`.
- **Full:**
  - `wgray_next` = Gray(`wbin_next`).
  - `wr_full` <= (`wgray_next` == {~`rd_ptr_sync`[add_size:add_size-1], `rd_ptr_sync`[add_size-2:0]}).
- **Level:**
  - `rbin` = Gray-to-binary of `rd_ptr_sync` (XOR prefix from the MSB).
  - `wr_level` <= `wbin_next` − `rbin`, modulo 2^(add_size+1).
- **Overflow:** `wr_ovf` <= `wr_ovf` | (`wr_en` & `wr_full`). It clears only on reset.
- **Write while full:** pointer, address and level hold; no memory write occurs.
- **Wrap-around:**
  - `wbin` wraps from 2^(add_size+1)−1 to 0.
  - `wr_addr` wraps from 2^add_size−1 to 0.
  - The Gray MSB toggles each lap, which distinguishes full from empty.
- **Simultaneous write and read advance:** both are folded into the same edge. `wr_full` and `wr_level` use `wbin_next` and the current `rd_ptr_sync`.
- **Pessimism:** full deassertion and level decrease lag the real read by the synchronizer latency. No false "not full" is ever reported.

## Timing
- **Reset values:** `wbin`, `wr_ptr`, `wr_addr`, `wr_level` = 0; `wr_full`, `wr_ovf`, `wr_almost_full` = 0.
- **Reset mid-operation:** all outputs return to reset values asynchronously, without waiting for a clock edge.
- **Pointer outputs:** `wr_addr` and `wr_ptr` update on the edge that accepts a write. The data for that write uses the pre-edge `wr_addr`.
- **Full, zero lag:** `wr_full` asserts on the same edge that accepts the write filling the last entry. `wr_mem_en` is low from the next cycle.
- **Full deassert:** `wr_full` deasserts on the first edge after `rd_ptr_sync` advances.
- **`wr_level`:** valid the cycle after each edge, with the same lag rules as `wr_full`.
- **`wr_ovf`:** sets on the edge following a rejected request.

## Configuration
- **Macro:** `WPTR_ALMOST_FULL_EN`.
- **Defined:**
  - Port `wr_almost_full` exists.
  - `wr_almost_full` <= ((`wbin_next` − `rbin`) ≥ `AF_LEVEL`), using the same arithmetic as `wr_level`.
  - Reset value 0.
- **Undefined:** the port and its register are absent; `AF_LEVEL` is ignored. All other behaviour is identical.

## Test plan
All scenarios use `add_size` = 8.
- **Reset:** drive `wr_rst` = 0 with random inputs -> all outputs 0; `wr_mem_en` = 0 only while `wr_full` = 0 and `wr_en` = 0.
- **Fill:** with `rd_ptr_sync` = 0, do 256 consecutive writes ->
  - `wr_full` = 1 after the 256th edge;
  - `wr_addr` = 0x00, `wr_ptr` = 0x180, `wr_level` = 256.
- **Overflow:** write while full -> `wr_addr`, `wr_ptr` and `wr_level` unchanged; `wr_mem_en` = 0; `wr_ovf` = 1 and stays 1 until reset.
- **Drain one:** from full, set `rd_ptr_sync` = 0x001 with `wr_en` = 0 -> next edge `wr_full` = 0, `wr_level` = 255. Then do a write and a read on the same edge -> level holds.
- **Wrap:** advance the write pointer through 512 writes while `rd_ptr_sync` tracks it -> `wbin` wraps to 0, `wr_ptr` returns to 0x000, and `wr_full` never asserts.
- **Almost-full and async reset:** with `WPTR_ALMOST_FULL_EN` and `AF_LEVEL` = 252 ->
  - `wr_almost_full` rises on the 252nd write;
  - assert `wr_rst` mid-burst -> outputs clear before the next `wr_clk` edge.
